// File: rtl/sdram_m9k_responder_if.sv
// sdram_m9k_responder_if
//
// Purpose: bundles the 16-bit SDRAM request/done bus between the MMU
// memory-port manager (master) and the SDRAM responder (slave).
//
// Signals:
//   SDRAM_pll_locked  responder -> master  emulated PLL lock
//   SDRAM_ready       responder -> master  idle and able to accept a request
//   SDRAM_as          master -> responder  one-cycle address strobe
//   SDRAM_rw          master -> responder  1 = read, 0 = write
//   SDRAM_addr        master -> responder  23-bit word address
//   SDRAM_data_write  master -> responder  16-bit write data
//   SDRAM_data_read   responder -> master  16-bit read data
//   SDRAM_done        responder -> master  one-cycle completion pulse
//   protocol_err      responder -> master  sticky protocol violation flag
interface sdram_m9k_responder_if;
  logic        SDRAM_pll_locked;
  logic        SDRAM_ready;
  logic        SDRAM_as;
  logic        SDRAM_rw;
  logic [22:0] SDRAM_addr;
  logic [15:0] SDRAM_data_write;
  logic [15:0] SDRAM_data_read;
  logic        SDRAM_done;
  logic        protocol_err;

  modport master (
    input  SDRAM_pll_locked, SDRAM_ready, SDRAM_data_read, SDRAM_done, protocol_err,
    output SDRAM_as, SDRAM_rw, SDRAM_addr, SDRAM_data_write
  );

  modport slave (
    output SDRAM_pll_locked, SDRAM_ready, SDRAM_data_read, SDRAM_done, protocol_err,
    input  SDRAM_as, SDRAM_rw, SDRAM_addr, SDRAM_data_write
  );
endinterface

// File: rtl/sdram_m9k_responder.sv
// sdram_m9k_responder
//
// Purpose: stands in for the off-chip SDRAM controller. Requests from the
// MMU memory-port manager are served from an on-chip word array while the
// responder reproduces power-up lock, initialization, periodic refresh
// stalls and fixed read/write latencies, so the MMU and worker datapath can
// be exercised without the physical SDRAM.
//
// Ports:
//   clk    in   single clock
//   rst_l  in   synchronous active-low reset
//   bus    slave side of sdram_m9k_responder_if (request/done bus)
//
// Parameters:
//   DEPTH_LOG2      array holds 2^DEPTH_LOG2 16-bit words (upper address bits alias)
//   LOCK_CYCLES     cycles after reset before pll_locked rises
//   INIT_CYCLES     cycles after lock before ready first rises
//   READ_LAT        accept-to-done cycles for reads (>= 2)
//   WRITE_LAT       accept-to-done cycles for writes (>= 1)
//   REFRESH_PERIOD  idle/busy cycles between refresh requests
//   REFRESH_CYCLES  length of one refresh stall
module sdram_m9k_responder #(
  parameter int DEPTH_LOG2     = 12,
  parameter int LOCK_CYCLES    = 16,
  parameter int INIT_CYCLES    = 32,
  parameter int READ_LAT       = 4,
  parameter int WRITE_LAT      = 2,
  parameter int REFRESH_PERIOD = 512,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_l,
  sdram_m9k_responder_if.slave bus
);

  localparam int MAX_A   = (LOCK_CYCLES > INIT_CYCLES) ? LOCK_CYCLES : INIT_CYCLES;
  localparam int MAX_B   = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CNT = (MAX_C > REFRESH_CYCLES) ? MAX_C : REFRESH_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int TMR_W   = $clog2(REFRESH_PERIOD + 1);
  localparam int DEPTH   = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    LOCK,
    INIT,
    IDLE,
    BUSY,
    REFRESH
  } state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic                  accept;
  logic                  start_refresh;
  logic                  lock_done;
  logic                  ready;
  logic                  done;

  logic                  pll_locked;
  logic                  rw_q;
  logic                  refresh_pending;
  logic [TMR_W-1:0]      refresh_timer;
  logic                  perr;
  logic [15:0]           data_read;
  logic [15:0]           hold;
  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] word_addr;
  logic                  unused_addr_bits;

  // Upper address bits alias onto the same word, so they are simply dropped.
  assign word_addr        = bus.SDRAM_addr[DEPTH_LOG2-1:0];
  assign unused_addr_bits = ^bus.SDRAM_addr[22:DEPTH_LOG2];

  // State register and the shared down-counter. Every phase loads the counter
  // with its length minus one on entry and leaves on the cycle it reads zero.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state <= LOCK;
      cnt   <= CNT_W'(LOCK_CYCLES - 1);
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and handshake outputs. In IDLE a strobe takes priority over a
  // pending refresh; the refresh is picked up when that access completes.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    accept        = 1'b0;
    start_refresh = 1'b0;
    lock_done     = 1'b0;
    ready         = 1'b0;
    done          = 1'b0;
    if (cnt != '0) cnt_next = cnt - 1'b1;
    case (state)
      LOCK: begin
        if (cnt == '0) begin
          state_next = INIT;
          cnt_next   = CNT_W'(INIT_CYCLES - 1);
          lock_done  = 1'b1;
        end
      end
      INIT: begin
        if (cnt == '0) state_next = IDLE;
      end
      IDLE: begin
        ready = 1'b1;
        if (bus.SDRAM_as) begin
          accept     = 1'b1;
          state_next = BUSY;
          cnt_next   = bus.SDRAM_rw ? CNT_W'(READ_LAT - 1) : CNT_W'(WRITE_LAT - 1);
        end else if (refresh_pending) begin
          start_refresh = 1'b1;
          state_next    = REFRESH;
          cnt_next      = CNT_W'(REFRESH_CYCLES - 1);
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          done = 1'b1;
          if (refresh_pending) begin
            start_refresh = 1'b1;
            state_next    = REFRESH;
            cnt_next      = CNT_W'(REFRESH_CYCLES - 1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      REFRESH: begin
        if (cnt == '0) state_next = IDLE;
      end
      default: begin
        state_next = LOCK;
      end
    endcase
  end

  // Control-side registers: lock flag, latched direction, read data output,
  // sticky protocol error and the refresh timer. The timer only advances in
  // IDLE/BUSY and saturates once the period is reached so pending stays set.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      pll_locked      <= 1'b0;
      rw_q            <= 1'b0;
      data_read       <= 16'h0000;
      perr            <= 1'b0;
      refresh_timer   <= '0;
      refresh_pending <= 1'b0;
    end else begin
      if (lock_done) pll_locked <= 1'b1;
      if (accept) rw_q <= bus.SDRAM_rw;
      if (state == BUSY && rw_q && cnt == CNT_W'(1)) data_read <= hold;
      if (bus.SDRAM_as && state != IDLE) perr <= 1'b1;
      if (start_refresh) begin
        refresh_timer   <= '0;
        refresh_pending <= 1'b0;
      end else if (state == IDLE || state == BUSY) begin
        if (refresh_timer == TMR_W'(REFRESH_PERIOD - 1)) refresh_pending <= 1'b1;
        if (refresh_timer != TMR_W'(REFRESH_PERIOD)) refresh_timer <= refresh_timer + 1'b1;
      end
    end
  end

  // Word array kept free of reset so it maps onto block RAM. Writes commit on
  // the acceptance edge; reads are fetched on the same edge into a holding
  // register and only copied to the output in the final busy cycle.
  always_ff @(posedge clk) begin
    if (accept && rst_l && !bus.SDRAM_rw) mem[word_addr] <= bus.SDRAM_data_write;
    if (accept && rst_l && bus.SDRAM_rw) hold <= mem[word_addr];
  end

  assign bus.SDRAM_pll_locked = pll_locked;
  assign bus.SDRAM_ready      = ready;
  assign bus.SDRAM_done       = done;
  assign bus.SDRAM_data_read  = data_read;
  assign bus.protocol_err     = perr;

endmodule

// File: tb/tb_sdram_m9k_responder.sv
// tb_sdram_m9k_responder
//
// Purpose: self-checking bench for sdram_m9k_responder. A behavioural model
// (word map keyed by aliased address, expected read data, sticky error flag
// and a count of idle/busy cycles for refresh scheduling) predicts every
// output from the timing rules of the responder.
//
// Ports: none (top-level bench); drives the DUT through sdram_m9k_responder_if.
module tb_sdram_m9k_responder;

  localparam int DEPTH_LOG2     = 12;
  localparam int LOCK_CYCLES    = 16;
  localparam int INIT_CYCLES    = 32;
  localparam int READ_LAT       = 4;
  localparam int WRITE_LAT      = 2;
  localparam int REFRESH_PERIOD = 512;
  localparam int REFRESH_CYCLES = 8;

  logic clk = 1'b0;
  logic rst_l;

  sdram_m9k_responder_if bus ();

  sdram_m9k_responder #(
    .DEPTH_LOG2    (DEPTH_LOG2),
    .LOCK_CYCLES   (LOCK_CYCLES),
    .INIT_CYCLES   (INIT_CYCLES),
    .READ_LAT      (READ_LAT),
    .WRITE_LAT     (WRITE_LAT),
    .REFRESH_PERIOD(REFRESH_PERIOD),
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] model_mem [int];
  logic [15:0] exp_rdata;
  bit          exp_perr;
  int          active;

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.SDRAM_as         = 1'b0;
    bus.SDRAM_rw         = 1'b0;
    bus.SDRAM_addr       = '0;
    bus.SDRAM_data_write = '0;
  endtask

  // Hold reset for a few edges; the array model survives reset.
  task automatic apply_reset();
    rst_l = 1'b0;
    idle_bus();
    repeat (3) tick();
    exp_rdata = 16'h0000;
    exp_perr  = 1'b0;
    active    = 0;
  endtask

  // Release reset and run to the first ready cycle without per-cycle checks.
  task automatic power_up();
    rst_l = 1'b1;
    repeat (LOCK_CYCLES + INIT_CYCLES) tick();
    tests++;
    if ({bus.SDRAM_pll_locked, bus.SDRAM_ready} !== 2'b11) begin
      fails++;
      $display("[TB] FAIL power_up_ready: locked/ready=%b required 11", {bus.SDRAM_pll_locked, bus.SDRAM_ready});
    end
    active = 0;
  endtask

  // Release reset and check lock/ready timing cycle by cycle; edge 0 is the
  // first edge that samples rst_l high.
  task automatic release_and_check_powerup();
    logic [3:0] exp;
    rst_l = 1'b1;
    for (int e = 0; e < 60; e++) begin
      if (e >= LOCK_CYCLES + INIT_CYCLES) active++;
      tick();
      exp = {(e >= LOCK_CYCLES - 1), (e >= LOCK_CYCLES + INIT_CYCLES - 1), 1'b0, 1'b0};
      tests++;
      if ({bus.SDRAM_pll_locked, bus.SDRAM_ready, bus.SDRAM_done, bus.protocol_err} !== exp) begin
        fails++;
        $display("[TB] FAIL powerup_e%0d: locked/ready/done/err=%b required %b", e,
                 {bus.SDRAM_pll_locked, bus.SDRAM_ready, bus.SDRAM_done, bus.protocol_err}, exp);
      end
    end
  endtask

  // One complete access, from strobe to return to ready. Optionally strobes
  // an illegal write while busy, or raises a held read strobe inside a
  // refresh stall that the next call then gets accepted.
  task automatic access(input bit rw, input logic [22:0] addr, input logic [15:0] wdata,
                        input bit poke_busy, input bit poke_refresh, output bit refreshed);
    int          lat;
    int          waited;
    bit          due;
    logic [11:0] idx;
    lat       = rw ? READ_LAT : WRITE_LAT;
    idx       = addr[11:0];
    refreshed = 1'b0;
    due       = 1'b0;
    waited    = 0;
    while (bus.SDRAM_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (bus.SDRAM_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("[TB] FAIL access_wait: ready=%b required 1 within 50 cycles", bus.SDRAM_ready);
      return;
    end
    bus.SDRAM_as         = 1'b1;
    bus.SDRAM_rw         = rw;
    bus.SDRAM_addr       = addr;
    bus.SDRAM_data_write = wdata;
    tick();
    active++;
    bus.SDRAM_as = 1'b0;
    if (!rw) model_mem[int'(idx)] = wdata;
    for (int k = 1; k <= lat; k++) begin
      if (poke_busy && k == 1) begin
        bus.SDRAM_as         = 1'b1;
        bus.SDRAM_rw         = 1'b0;
        bus.SDRAM_data_write = ~wdata;
        exp_perr             = 1'b1;
      end else if (poke_busy && k == 2) begin
        bus.SDRAM_as = 1'b0;
      end
      if (k == lat && rw) exp_rdata = model_mem[int'(idx)];
      tests++;
      if ({bus.SDRAM_ready, bus.SDRAM_done} !== {1'b0, (k == lat)}) begin
        fails++;
        $display("[TB] FAIL busy_flags_k%0d: ready/done=%b required %b", k,
                 {bus.SDRAM_ready, bus.SDRAM_done}, {1'b0, (k == lat)});
      end
      tests++;
      if (bus.SDRAM_data_read !== exp_rdata) begin
        fails++;
        $display("[TB] FAIL read_data_k%0d: data_read=%h required %h", k, bus.SDRAM_data_read, exp_rdata);
      end
      if (k == lat) due = (active >= REFRESH_PERIOD);
      else active++;
      tick();
    end
    active++;
    if (due) begin
      refreshed = 1'b1;
      active    = 0;
      for (int r = 0; r < REFRESH_CYCLES; r++) begin
        if (poke_refresh && r == 2) begin
          bus.SDRAM_as   = 1'b1;
          bus.SDRAM_rw   = 1'b1;
          bus.SDRAM_addr = addr;
          exp_perr       = 1'b1;
        end
        tests++;
        if ({bus.SDRAM_ready, bus.SDRAM_done} !== 2'b00) begin
          fails++;
          $display("[TB] FAIL refresh_r%0d: ready/done=%b required 00", r, {bus.SDRAM_ready, bus.SDRAM_done});
        end
        tick();
      end
    end
    tests++;
    if ({bus.SDRAM_ready, bus.SDRAM_done} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL after_done: ready/done=%b required 10", {bus.SDRAM_ready, bus.SDRAM_done});
    end
    tests++;
    if (bus.protocol_err !== exp_perr) begin
      fails++;
      $display("[TB] FAIL protocol_err: err=%b required %b", bus.protocol_err, exp_perr);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (bus.SDRAM_pll_locked !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_locked: %b required 0", bus.SDRAM_pll_locked);
    end
    tests++;
    if (bus.SDRAM_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_ready: %b required 0", bus.SDRAM_ready);
    end
    tests++;
    if (bus.SDRAM_done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_done: %b required 0", bus.SDRAM_done);
    end
    tests++;
    if (bus.SDRAM_data_read !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL reset_data: %h required 0000", bus.SDRAM_data_read);
    end
    tests++;
    if (bus.protocol_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_err: %b required 0", bus.protocol_err);
    end
  endtask

  task automatic test_power_up();
    release_and_check_powerup();
  endtask

  task automatic test_write_read();
    bit r;
    access(1'b0, 23'h000123, 16'hBEEF, 1'b0, 1'b0, r);
    access(1'b1, 23'h000123, 16'h0000, 1'b0, 1'b0, r);
    for (int i = 0; i < 10; i++) begin
      active++;
      tick();
      tests++;
      if ({bus.SDRAM_ready, bus.SDRAM_done, bus.SDRAM_data_read} !== {2'b10, 16'hBEEF}) begin
        fails++;
        $display("[TB] FAIL hold_i%0d: ready/done=%b data=%h required 10 beef", i,
                 {bus.SDRAM_ready, bus.SDRAM_done}, bus.SDRAM_data_read);
      end
    end
  endtask

  task automatic test_alias();
    bit r;
    access(1'b0, 23'h001005, 16'h1234, 1'b0, 1'b0, r);
    access(1'b1, 23'h000005, 16'h0000, 1'b0, 1'b0, r);
    tests++;
    if (bus.SDRAM_data_read !== 16'h1234) begin
      fails++;
      $display("[TB] FAIL alias_read: data=%h required 1234", bus.SDRAM_data_read);
    end
  endtask

  task automatic test_protocol();
    bit r;
    access(1'b1, 23'h000123, 16'h0000, 1'b1, 1'b0, r);
    access(1'b1, 23'h400123, 16'h0000, 1'b0, 1'b0, r);
  endtask

  task automatic test_random();
    logic [11:0] pool [6];
    logic [22:0] addr;
    bit          rw;
    bit          r;
    int          j;
    apply_reset();
    power_up();
    for (int i = 0; i < 6; i++) pool[i] = 12'($urandom);
    for (int n = 0; n < 40; n++) begin
      j    = $urandom_range(0, 5);
      addr = {11'($urandom), pool[j]};
      rw   = 1'($urandom_range(0, 1));
      if (!model_mem.exists(int'(pool[j]))) rw = 1'b0;
      access(rw, addr, 16'($urandom), 1'b0, 1'b0, r);
      repeat ($urandom_range(0, 2)) begin
        active++;
        tick();
        tests++;
        if ({bus.SDRAM_ready, bus.SDRAM_done} !== 2'b10) begin
          fails++;
          $display("[TB] FAIL random_gap: ready/done=%b required 10", {bus.SDRAM_ready, bus.SDRAM_done});
        end
      end
    end
  endtask

  task automatic test_refresh();
    bit seen;
    bit r;
    apply_reset();
    power_up();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) access(1'b1, 23'h000123, 16'h0000, 1'b0, 1'b1, seen);
    tests++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL refresh_seen: refreshed=0 required 1 within 200 reads");
    end
    access(1'b1, 23'h000123, 16'h0000, 1'b0, 1'b0, r);
  endtask

  task automatic test_reset_mid_read();
    bit r;
    bus.SDRAM_as   = 1'b1;
    bus.SDRAM_rw   = 1'b1;
    bus.SDRAM_addr = 23'h000123;
    tick();
    bus.SDRAM_as = 1'b0;
    rst_l        = 1'b0;
    tests++;
    if ({bus.SDRAM_ready, bus.SDRAM_done} !== 2'b00) begin
      fails++;
      $display("[TB] FAIL midread_busy: ready/done=%b required 00", {bus.SDRAM_ready, bus.SDRAM_done});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if ({bus.SDRAM_pll_locked, bus.SDRAM_ready, bus.SDRAM_done, bus.protocol_err, bus.SDRAM_data_read}
          !== {4'b0000, 16'h0000}) begin
        fails++;
        $display("[TB] FAIL midread_reset_i%0d: locked/ready/done/err=%b data=%h required 0000 0000", i,
                 {bus.SDRAM_pll_locked, bus.SDRAM_ready, bus.SDRAM_done, bus.protocol_err}, bus.SDRAM_data_read);
      end
    end
    exp_rdata = 16'h0000;
    exp_perr  = 1'b0;
    active    = 0;
    release_and_check_powerup();
    access(1'b1, 23'h000123, 16'h0000, 1'b0, 1'b0, r);
  endtask

  initial begin
    rst_l = 1'b0;
    idle_bus();
    test_reset();
    test_power_up();
    test_write_read();
    test_alias();
    test_protocol();
    test_random();
    test_refresh();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
